// File: rtl/lsu_mem_if.sv
// Load/store unit between the multi-cycle controller and word-wide data memory.
// Decodes one access per start, steers byte lanes, runs req/ack, and returns extended load data.
module lsu_mem_if #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISALIGN = 2'd1;
  localparam logic [1:0] FC_BADOP    = 2'd2;
  localparam logic [1:0] FC_TIMEOUT  = 2'd3;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_ERR
  } state_e;

  function automatic logic op_valid(input logic [5:0] op);
    logic ok;
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: ok = 1'b1;
      default:                                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic op_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Byte accesses can never be misaligned.
  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] k);
    logic bad;
    case (op)
      OP_LH, OP_LHU, OP_SH: bad = k[0];
      OP_LW, OP_SW:         bad = (k != 2'b00);
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_be(input logic [5:0] op, input logic [1:0] k);
    logic [3:0] be;
    case (op)
      OP_SB:   be = 4'b0001 << k;
      OP_SH:   be = k[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [5:0] op, input logic [31:0] wd);
    logic [31:0] r;
    case (op)
      OP_SB:   r = {4{wd[7:0]}};
      OP_SH:   r = {2{wd[15:0]}};
      OP_SW:   r = wd;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extend_load(input logic [5:0] op, input logic [1:0] k,
                                              input logic [31:0] word);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] r_s;
    logic        [31:0] r;
    b   = word[{k, 3'b000} +: 8];
    h   = k[1] ? word[31:16] : word[15:0];
    b_s = $signed(b);
    h_s = $signed(h);
    r   = word;
    case (op)
      OP_LB:  begin r_s = b_s; r = $unsigned(r_s); end
      OP_LH:  begin r_s = h_s; r = $unsigned(r_s); end
      OP_LBU: r = {24'h0, b};
      OP_LHU: r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         op_q, op_d;
  logic [1:0]         k_q, k_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fault_q, fault_d;
  logic [1:0]         fault_code_q, fault_code_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [3:0]         mem_be_q, mem_be_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               tmo_hit;

  assign tmo_hit = (TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    k_d          = k_q;
    done_d       = 1'b0;
    fault_d      = 1'b0;
    fault_code_d = fault_code_q;
    rdata_d      = rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d         = opcode;
          k_d          = addr[1:0];
          fault_code_d = FC_NONE;
          if (!op_valid(opcode)) begin
            state_d      = S_ERR;
            fault_d      = 1'b1;
            fault_code_d = FC_BADOP;
          end else if (misaligned(opcode, addr[1:0])) begin
            state_d      = S_ERR;
            fault_d      = 1'b1;
            fault_code_d = FC_MISALIGN;
          end else begin
            state_d     = S_REQ;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = op_store(opcode);
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = lane_be(opcode, addr[1:0]);
            mem_wdata_d = lane_wdata(opcode, wdata);
          end
        end
      end
      S_REQ: begin
        // An ack coinciding with timeout expiry still completes the access.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_DONE;
          done_d    = 1'b1;
          if (!op_store(op_q)) begin
            rdata_d = extend_load(op_q, k_q, mem_rdata);
          end
        end else if (tmo_hit) begin
          mem_req_d    = 1'b0;
          state_d      = S_ERR;
          fault_d      = 1'b1;
          fault_code_d = FC_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      k_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= '0;
      rdata_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      k_q          <= k_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      rdata_q      <= rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign rdata      = rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store unit directly downstream of the multi-cycle controller's memory states.
- Accepts one load or store per start pulse: opcode, effective address from the ALU, and rt store data.
- Performs byte-lane steering and alignment checks, then runs a req/ack handshake to word-wide data memory.
- Returns sign- or zero-extended load data to the register-file write-data mux.

Parameters:
TIMEOUT, 16, max REQ cycles waiting for mem_ack before faulting; 0 disables timeout

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
opcode  in  6  instruction[31:26]: 0x20 lb, 0x21 lh, 0x23 lw, 0x24 lbu, 0x25 lhu, 0x28 sb, 0x29 sh, 0x2b sw
addr  in  32  effective byte address
wdata  in  32  store data (rt)
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse: access completed successfully
rdata  out  32  extended load result; held until next successful load
fault  out  1  one-cycle pulse: access aborted
fault_code  out  2  0 none, 1 misaligned, 2 bad opcode, 3 timeout; held until next start accepted
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 store, 0 load
mem_addr  out  32  {addr[31:2],2'b00}
mem_be  out  4  byte enables, bit k = bits 8k+7:8k
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  read word, valid with mem_ack
mem_ack  in  1  completes request in the cycle it is sampled high with mem_req

Behaviour:
- Reset (rst_n=0 at edge):
  - state=IDLE, timeout counter=0.
  - All outputs 0: busy, done, fault, fault_code, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata.
  - Reset mid-REQ drops mem_req at that edge; any later mem_ack is ignored.
- All outputs are registered. States: IDLE, REQ, DONE, ERR.
- IDLE + start:
  - Latch opcode and addr; clear fault_code to 0.
  - Unknown opcode -> ERR with code 2.
  - Misaligned -> ERR with code 1. Misaligned means lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0. Byte accesses are never misaligned.
  - Otherwise -> REQ with mem_req=1 from the next cycle.
  - No mem_req is ever issued for a faulting access.
- Lane rules, k=addr[1:0], little-endian:
  - sb: be=1<<k; wdata byte replicated in all 4 lanes.
  - sh: be=0011 if k=0, 1100 if k=2; halfword replicated in both halves.
  - sw: be=1111, wdata unchanged.
  - Loads: be=1111, mem_we=0.
- REQ:
  - mem_req, mem_we, mem_addr, mem_be, mem_wdata are stable until ack.
  - Ack may arrive in the first REQ cycle.
  - On edge with mem_ack=1: for loads, extract the byte/halfword lane and extend. lb/lh sign-extend, lbu/lhu zero-extend, lw passes through. Write the result into rdata. Stores leave rdata unchanged. mem_req->0; state->DONE.
  - Timeout counter starts at 0 on REQ entry and increments each REQ cycle without ack.
  - With TIMEOUT>0, when counter==TIMEOUT-1 and mem_ack=0: mem_req->0, state->ERR, code 3.
  - Ack in the same cycle as timeout expiry wins (completes normally).
- DONE: done=1 for exactly one cycle, then IDLE.
- ERR: fault=1 for exactly one cycle, then IDLE.
- Start pulses outside IDLE are ignored; no queuing.
- done and fault are never high together.
- Latency:
  - Start sampled at edge N; mem_req high after N.
  - Ack sampled at edge M; done high in the cycle after M.
  - Minimum start-to-done is 2 edges. Fault appears 1 edge after start for alignment/opcode faults.
- mem_ack while mem_req=0 is ignored.

Test Plan:
- lb at addr 0x103, mem_rdata 0x80FF_1234, ack in 1st REQ cycle -> mem_addr 0x100, be 1111, done 2 cycles after start, rdata 0xFFFF_FF80. Same access as lbu -> rdata 0x0000_0080.
- sh at addr 0x22, wdata 0x1234_ABCD, ack after 3 REQ cycles -> mem_we=1, be 1100, mem_wdata 0xABCD_ABCD, signals stable for all 3 cycles, done pulse, rdata unchanged.
- lw at 0x201 -> fault=1 with code 1 one cycle after start, mem_req never asserted. Opcode 0x22 -> fault with code 2.
- TIMEOUT=16, lw at 0x40, no ack -> mem_req high exactly 16 cycles, then fault with code 3. Rerun with ack on the 16th REQ cycle -> done, no fault.
- Second start while busy (REQ) -> ignored, one done only. rst_n=0 mid-REQ -> mem_req 0 after that edge, all outputs 0, subsequent ack produces no done.
- Back-to-back: start lhu at 0x12 (rdata word 0x9ABC_0000) immediately when busy falls -> rdata 0x0000_9ABC, each access yields exactly one done pulse.
